// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a show-ahead byte FIFO.
//
// Ports:
//   clock          - single clock, all state changes on its rising edge
//   reset          - asynchronous, active-low reset
//   uart_rx        - asynchronous serial input, idle high, LSB first
//   data_out       - byte at the FIFO head
//   data_out_valid - FIFO non-empty, data_out meaningful
//   data_out_ready - consumer takes data_out this cycle
//   fill_count     - number of bytes stored (0..2^DEPTH_LOG2)
//   framing_error  - sticky: a stop bit sampled low
//   overflow       - sticky: a received byte was dropped on a full FIFO
//   clear_errors   - synchronous clear of both sticky flags (set wins)
module uart_rx_buffer #(
    parameter int CLOCK_DIVIDER = 104,
    parameter int DEPTH_LOG2    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                uart_rx,
    output logic [7:0]          data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic [DEPTH_LOG2:0] fill_count,
    output logic                framing_error,
    output logic                overflow,
    input  logic                clear_errors
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLOCK_DIVIDER + 1);

    localparam logic [CW-1:0]         HALF_BIT = CW'(CLOCK_DIVIDER / 2 - 1);
    localparam logic [CW-1:0]         FULL_BIT = CW'(CLOCK_DIVIDER - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   FILL_ONE = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    // ---------------- input synchronizer (idles high) ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- receiver FSM ----------------
    rx_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        rx_push, frame_err_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CNT_ONE;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                // Re-check the start bit mid-way; a high line here was a glitch.
                if (cnt == HALF_BIT) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_BIT) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_sync;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == FULL_BIT) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        rx_push    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Park here through a break so it reports only one error.
                cnt_next = '0;
                if (rx_sync) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- show-ahead FIFO ----------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic                  pop, full, push_ok;

    assign data_out_valid = (fill_count != '0);
    assign data_out       = mem[rd_ptr];
    assign pop            = data_out_valid && data_out_ready;
    assign full           = fill_count[DEPTH_LOG2];
    // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
    assign push_ok        = rx_push && (!full || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)      fill_count <= fill_count + FILL_ONE;
            else if (!push_ok && pop) fill_count <= fill_count - FILL_ONE;
        end
    end

    // ---------------- sticky flags (set beats clear) ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            framing_error <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (frame_err_set)     framing_error <= 1'b1;
            else if (clear_errors) framing_error <= 1'b0;
            if (rx_push && !push_ok) overflow <= 1'b1;
            else if (clear_errors)   overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: scoreboard queue of expected bytes
// filled as frames are sent and drained against the FIFO output.
module tb_uart_rx_buffer;
    localparam int BIT = 104;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready = 1'b0;
    logic [4:0] fill_count;
    logic       framing_error;
    logic       overflow;
    logic       clear_errors = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int n;
    int rises;

    uart_rx_buffer #(.CLOCK_DIVIDER(BIT), .DEPTH_LOG2(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .fill_count    (fill_count),
        .framing_error (framing_error),
        .overflow      (overflow),
        .clear_errors  (clear_errors)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame; stop level and extra low hold are selectable for breaks.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_bits);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clock);
        end
        uart_rx = stop;
        repeat (BIT * (1 + hold_bits)) @(negedge clock);
        uart_rx = 1'b1;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            int w = 0;
            while (!data_out_valid && w < 2000) begin
                @(negedge clock);
                w++;
            end
            if (!data_out_valid) begin
                chk({tag, "_valid"}, data_out_valid, 1);
                exp_q.delete();
                return;
            end
            chk(tag, data_out, exp_q.pop_front());
            data_out_ready = 1'b1;
            @(negedge clock);
            data_out_ready = 1'b0;
        end
        @(negedge clock);
        chk({tag, "_empty"}, data_out_valid, 0);
    endtask

    initial begin
        // ---- reset state ----
        repeat (5) @(negedge clock);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_fill", fill_count, 0);
        chk("rst_ferr", framing_error, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // ---- 0x55 latency, ready held low ----
        exp_q.push_back(8'h55);
        n = 0;
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                @(negedge uart_rx);
                while (n < 1500) begin
                    @(posedge clock);
                    n++;
                    #1;
                    if (data_out_valid) break;
                end
            end
        join
        chk("lat_0x55", n, 991);
        chk("fill_0x55", fill_count, 1);
        drain("byte_0x55");

        // ---- 30-cycle glitch, then a clean byte ----
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (30) @(negedge clock);
        uart_rx = 1'b1;
        repeat (300) @(negedge clock);
        chk("glitch_fill", fill_count, 0);
        chk("glitch_ferr", framing_error, 0);
        chk("glitch_ovf", overflow, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 0);
        drain("after_glitch");

        // ---- framing error with a 3-bit break, cleared once seen ----
        rises = 0;
        fork
            send_frame(8'hA3, 1'b0, 3);
            begin
                logic prev = 1'b0;
                bit cleared = 1'b0;
                for (int c = 0; c < 1500; c++) begin
                    @(negedge clock);
                    if (framing_error && !prev) rises++;
                    prev = framing_error;
                    if (framing_error && !cleared) begin
                        clear_errors = 1'b1;
                        cleared = 1'b1;
                    end else begin
                        clear_errors = 1'b0;
                    end
                end
            end
        join
        chk("ferr_events", rises, 1);
        chk("ferr_cleared", framing_error, 0);
        chk("ferr_fill", fill_count, 0);
        chk("ferr_ovf", overflow, 0);

        // ---- overflow: 17 bytes into a 16-deep FIFO ----
        for (int b = 0; b < 17; b++) begin
            if (b < 16) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0);
        end
        chk("ovf_fill", fill_count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_ferr", framing_error, 0);
        drain("ovf_drain");
        @(negedge clock);
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        chk("ovf_clear", overflow, 0);

        // ---- full FIFO, pop on the push cycle of 0x10 ----
        for (int b = 0; b < 16; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 0);
        end
        chk("full_fill", fill_count, 16);
        exp_q.push_back(8'h10);
        fork
            send_frame(8'h10, 1'b1, 0);
            begin
                @(negedge uart_rx);
                repeat (990) @(posedge clock);
                @(negedge clock);
                chk("full_head", data_out, exp_q.pop_front());
                data_out_ready = 1'b1;
                @(negedge clock);
                data_out_ready = 1'b0;
            end
        join
        chk("full_fill_after", fill_count, 16);
        chk("full_ovf", overflow, 0);
        drain("full_drain");

        // ---- reset during bit 4, then 0x3C ----
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            repeat (BIT) @(negedge clock);
        end
        uart_rx = 1'b0;
        repeat (BIT / 2) @(negedge clock);
        reset = 1'b0;
        uart_rx = 1'b1;
        repeat (10) @(negedge clock);
        chk("midrst_fill", fill_count, 0);
        reset = 1'b1;
        repeat (300) @(negedge clock);
        chk("midrst_idle_fill", fill_count, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0);
        chk("midrst_count", fill_count, 1);
        drain("midrst_byte");
        chk("midrst_ferr", framing_error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
